// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//
// Program-counter / next-address stage placed directly upstream of the
// return-address stack. Every enabled RUN cycle it selects the next PC from
// the decoded flow op (SEQ, JUMP, BRANCH, CALL, RET). CALL pushes the current
// PC (the stack itself stores PC+INC_VALUE); RET loads the PC from the stack
// top and pops. Stack occupancy is mirrored locally so an overflowing CALL or
// underflowing RET is blocked before the stack sees it, and is recorded in a
// sticky fault flag.
//
// Build option:
//   PC_SEQUENCER_TRAP_EN  defined   : a faulting op sends the PC to
//                                     TRAP_VECTOR and parks the FSM in TRAP
//                                     until reset.
//                         undefined : a faulting op advances like SEQ and
//                                     only the fault flag records it.
//
// Ports:
//   clk         in   clock, all state updates on posedge
//   reset       in   synchronous, active-high reset (shared with the stack)
//   en          in   advance enable; 0 freezes the PC and masks push/pop
//   op          in   flow op: 0 SEQ, 1 JUMP, 2 BRANCH, 3 CALL, 4 RET, 5-7 SEQ
//   cond        in   branch condition (BRANCH only)
//   target      in   jump/branch/call destination
//   stack_top   in   stack data_out (current return address)
//   stack_push  out  push strobe to the stack
//   stack_pop   out  pop strobe to the stack
//   stack_data  out  value pushed to the stack (the current PC)
//   pc          out  current instruction address (registered)
//   pc_valid    out  pc is a fetchable address (registered)
//   depth       out  mirrored stack occupancy
//   fault       out  sticky overflow/underflow flag
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module pc_sequencer #(
   parameter int                     ADDR_WIDTH   = 16,
   parameter int                     STACK_SIZE   = 16,
   parameter int                     INC_VALUE    = 4,
   parameter logic [ADDR_WIDTH-1:0]  RESET_VECTOR = '0,
   parameter logic [ADDR_WIDTH-1:0]  TRAP_VECTOR  = 16'hFFF0
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          en,
   input  logic [2:0]                    op,
   input  logic                          cond,
   input  logic [ADDR_WIDTH-1:0]         target,
   input  logic [ADDR_WIDTH-1:0]         stack_top,
   output logic                          stack_push,
   output logic                          stack_pop,
   output logic [ADDR_WIDTH-1:0]         stack_data,
   output logic [ADDR_WIDTH-1:0]         pc,
   output logic                          pc_valid,
   output logic [$clog2(STACK_SIZE):0]   depth,
   output logic                          fault
);

   localparam int                    DEPTH_W = $clog2(STACK_SIZE) + 1;
   localparam logic [DEPTH_W-1:0]    FULL    = DEPTH_W'(STACK_SIZE);
   localparam logic [ADDR_WIDTH-1:0] INC_W   = ADDR_WIDTH'(INC_VALUE);

   // Both vectors must be reachable by sequential stepping from themselves.
   if (INC_VALUE <= 0 ||
       (RESET_VECTOR % INC_W) != '0 ||
       (TRAP_VECTOR  % INC_W) != '0) begin : g_bad_vector
      $error("pc_sequencer: vectors must be multiples of a positive INC_VALUE");
   end

   typedef enum logic [2:0] {
      OP_SEQ    = 3'd0,
      OP_JUMP   = 3'd1,
      OP_BRANCH = 3'd2,
      OP_CALL   = 3'd3,
      OP_RET    = 3'd4
   } op_e;

`ifdef PC_SEQUENCER_TRAP_EN
   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_TRAP = 2'd2
   } state_e;
`else
   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1
   } state_e;
`endif

   state_e                 state_q, state_d;
   logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
   logic [DEPTH_W-1:0]     depth_q, depth_d;
   logic                   fault_q, fault_d;
   logic                   pc_valid_q, pc_valid_d;

   logic                   run_en;
   logic                   is_call;
   logic                   is_ret;
   logic                   call_fault;
   logic                   ret_fault;
   logic [ADDR_WIDTH-1:0]  seq_pc;

   assign run_en     = (state_q == ST_RUN) && en;
   assign is_call    = (op == OP_CALL);
   assign is_ret     = (op == OP_RET);
   assign call_fault = is_call && (depth_q == FULL);
   assign ret_fault  = is_ret  && (depth_q == '0);
   assign seq_pc     = pc_q + INC_W;   // wraps modulo 2^ADDR_WIDTH

   // Strobes depend only on registered state and the current op, so they are
   // stable well before the stack samples them. Reset masks them so a stack
   // sharing our reset never sees a stray push/pop in the reset cycle.
   assign stack_push = !reset && run_en && is_call && (depth_q != FULL);
   assign stack_pop  = !reset && run_en && is_ret  && (depth_q != '0);
   assign stack_data = pc_q;

   // NOTE: every variable gets a default at the top of the block, so no path
   // through the case statements can leave one unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      depth_d = depth_q;
      fault_d = fault_q;

      case (state_q)
         ST_BOOT: state_d = ST_RUN;   // ops ignored, PC stays at RESET_VECTOR

         ST_RUN: begin
            if (en) begin
               if (call_fault || ret_fault) begin
                  fault_d = 1'b1;
`ifdef PC_SEQUENCER_TRAP_EN
                  pc_d    = TRAP_VECTOR;
                  state_d = ST_TRAP;
`else
                  pc_d    = seq_pc;
`endif
               end else begin
                  case (op)
                     OP_JUMP:   pc_d = target;
                     OP_BRANCH: pc_d = cond ? target : seq_pc;
                     OP_CALL: begin
                        pc_d    = target;
                        depth_d = depth_q + DEPTH_W'(1);
                     end
                     OP_RET: begin
                        // stack_top already reflects any push made last cycle
                        pc_d    = stack_top;
                        depth_d = depth_q - DEPTH_W'(1);
                     end
                     default:   pc_d = seq_pc;   // SEQ and the spare codes 5-7
                  endcase
               end
            end
         end

`ifdef PC_SEQUENCER_TRAP_EN
         ST_TRAP: pc_d = TRAP_VECTOR;   // only reset leaves TRAP
`endif

         default: state_d = ST_BOOT;
      endcase

      // Registered so pc_valid changes on the same edge as pc.
      pc_valid_d = (state_d == ST_RUN);
   end

   // NOTE: reset is synchronous and sampled only on the clock edge, so it
   // sits inside the clocked branch rather than in the sensitivity list;
   // being checked first, it also overrides any op presented in that cycle.
   // NOTE: state uses non-blocking assignments so every flop samples the
   // pre-edge values computed above, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_BOOT;
         pc_q       <= RESET_VECTOR;
         depth_q    <= '0;
         fault_q    <= 1'b0;
         pc_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         depth_q    <= depth_d;
         fault_q    <= fault_d;
         pc_valid_q <= pc_valid_d;
      end
   end

   assign pc       = pc_q;
   assign pc_valid = pc_valid_q;
   assign depth    = depth_q;
   assign fault    = fault_q;

endmodule
